// File: rtl/snes_pad_responder.sv
// snes_pad_responder
// Controller-side end of the SNES serial pad protocol. The master drives
// latch and pad clock; this block loads the (inverted) button word on latch
// and shifts one bit per pad-clock rising edge onto the active-low data line.
// Both master inputs are asynchronous and are brought into the clk domain
// through two-flop synchronisers plus one delay flop for edge detection.
//
// Optional feature macro: SNES_PAD_TIMEOUT_EN
//   When defined, a frame left in SHIFT with no pad-clock activity for
//   TIMEOUT_CYCLES clk cycles is abandoned and the line returns to idle-high.
//   When undefined, SHIFT waits indefinitely for pad-clock edges.

module snes_pad_responder #(
    parameter int FRAME_BITS     = 16,
    parameter int TIMEOUT_CYCLES = 600000
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  latch_in,
    input  logic                  pad_clk_in,
    input  logic [FRAME_BITS-1:0] buttons,
    output logic                  data_out,
    output logic                  busy,
    output logic                  frame_done
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LOAD  = 2'd1,
        ST_SHIFT = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    localparam logic [4:0] LAST_CNT = 5'(FRAME_BITS);

    // Synchroniser and edge-detect flops
    logic latch_s1_r, latch_s2_r, latch_d_r;
    logic pad_s1_r, pad_s2_r, pad_d_r;

    // Edge strobes in the clk domain
    logic latch_rise_s;
    logic pad_rise_s;
    logic pad_edge_s;
    logic timeout_s;

    // Frame state
    state_t                state_r, state_n;
    logic [FRAME_BITS-1:0] shreg_r, shreg_n;
    logic [4:0]            bit_cnt_r, bit_cnt_n;
    logic                  frame_done_r, frame_done_n;
    logic                  busy_r, busy_n;

    // Two-flop synchronisers plus a delay stage; pad clock idles high
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            latch_s1_r <= 1'b0;
            latch_s2_r <= 1'b0;
            latch_d_r  <= 1'b0;
            pad_s1_r   <= 1'b1;
            pad_s2_r   <= 1'b1;
            pad_d_r    <= 1'b1;
        end else begin
            latch_s1_r <= latch_in;
            latch_s2_r <= latch_s1_r;
            latch_d_r  <= latch_s2_r;
            pad_s1_r   <= pad_clk_in;
            pad_s2_r   <= pad_s1_r;
            pad_d_r    <= pad_s2_r;
        end
    end

    assign latch_rise_s = latch_s2_r & ~latch_d_r;
    assign pad_rise_s   = pad_s2_r & ~pad_d_r;
    assign pad_edge_s   = pad_s2_r ^ pad_d_r;

`ifdef SNES_PAD_TIMEOUT_EN
    localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [TO_W-1:0] to_cnt_r;

    // Idle-time counter: runs only in SHIFT, cleared by any pad-clock edge
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            to_cnt_r <= TO_W'(0);
        end else if ((state_r != ST_SHIFT) || pad_edge_s) begin
            to_cnt_r <= TO_W'(0);
        end else begin
            to_cnt_r <= to_cnt_r + TO_W'(1);
        end
    end

    assign timeout_s = (state_r == ST_SHIFT) && !pad_edge_s &&
                       (to_cnt_r == TO_W'(TIMEOUT_CYCLES - 1));
`else
    assign timeout_s = 1'b0;
`endif

    // Next-state, shift-register and pulse logic; latch rise overrides all
    always_comb begin
        state_n      = state_r;
        shreg_n      = shreg_r;
        bit_cnt_n    = bit_cnt_r;
        frame_done_n = 1'b0;
        if (latch_rise_s) begin
            state_n   = ST_LOAD;
            shreg_n   = ~buttons;
            bit_cnt_n = 5'd0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    state_n = ST_IDLE;
                end
                ST_LOAD: begin
                    // Keep tracking the buttons while latch is high; the
                    // word present at latch fall is the one shifted out
                    if (latch_s2_r) begin
                        shreg_n   = ~buttons;
                        bit_cnt_n = 5'd0;
                    end else begin
                        state_n = ST_SHIFT;
                    end
                end
                ST_SHIFT: begin
                    if (timeout_s) begin
                        state_n   = ST_IDLE;
                        shreg_n   = {FRAME_BITS{1'b1}};
                        bit_cnt_n = 5'd0;
                    end else if (pad_rise_s) begin
                        shreg_n   = {1'b0, shreg_r[FRAME_BITS-1:1]};
                        bit_cnt_n = bit_cnt_r + 5'd1;
                        if ((bit_cnt_r + 5'd1) == LAST_CNT) begin
                            frame_done_n = 1'b1;
                            state_n      = ST_DONE;
                        end else begin
                            state_n = ST_SHIFT;
                        end
                    end else begin
                        state_n = ST_SHIFT;
                    end
                end
                ST_DONE: begin
                    // Extra clocks keep shifting in zeros; count saturates
                    if (pad_rise_s) begin
                        shreg_n = {1'b0, shreg_r[FRAME_BITS-1:1]};
                    end else begin
                        shreg_n = shreg_r;
                    end
                end
                default: begin
                    state_n   = ST_IDLE;
                    shreg_n   = {FRAME_BITS{1'b1}};
                    bit_cnt_n = 5'd0;
                end
            endcase
        end
        busy_n = (state_n == ST_LOAD) || (state_n == ST_SHIFT);
    end

    // State, shift register and registered status outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r      <= ST_IDLE;
            shreg_r      <= {FRAME_BITS{1'b1}};
            bit_cnt_r    <= 5'd0;
            frame_done_r <= 1'b0;
            busy_r       <= 1'b0;
        end else begin
            state_r      <= state_n;
            shreg_r      <= shreg_n;
            bit_cnt_r    <= bit_cnt_n;
            frame_done_r <= frame_done_n;
            busy_r       <= busy_n;
        end
    end

    assign data_out   = shreg_r[0];
    assign busy       = busy_r;
    assign frame_done = frame_done_r;

endmodule
